pwm_duty_decoder: RTL and testbench

//  Receive-side companion of our 8-bit PWM generator: measures the high time and period of an incoming PWM.

---
 rtl/pwm_duty_decoder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// pwm_duty_decoder
//
// Receive-side companion of the 8-bit PWM generator. Measures the high time
// and the period of an incoming PWM signal in prescaler ticks. The high time
// is reported as an 8-bit duty code, saturated at 255. With the generator's
// tick rate (DIV=19, one tick every 20 clk), a 256-tick frame decodes to the
// generator's own duty code.
//
// Parameters
//   DIV         prescaler terminal count; one tick every DIV+1 clk
//   TIMEOUT     ticks without a rising edge before a stuck report (2..511)
//
// Ports
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous reset, active low
//   ena         in   1  block enable; low parks the block in IDLE
//   pwm_in      in   1  asynchronous PWM input
//   duty_out    out  8  high ticks of the last complete frame (sat. 255)
//   period_out  out  9  ticks of the last complete frame
//   valid       out  1  one-clk pulse when duty_out/period_out update
//   stuck       out  1  1 = last report was a timeout, not a frame
//
// Optional feature (compile-time macro)
//   PWM_DECODER_GLITCH_FILTER_EN
//     defined:   the tick sample only follows the synchronised input when it
//                has been identical for the sampled clk and the 2 clk before;
//                otherwise the previous sample is kept. Pulses shorter than
//                3 clk are ignored.
//     undefined: the tick sample is the synchronised input, unfiltered.
// ---------------------------------------------------------------------------
module pwm_duty_decoder #(
   parameter int DIV     = 19,
   parameter int TIMEOUT = 511
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       pwm_in,
   output logic [7:0] duty_out,
   output logic [8:0] period_out,
   output logic       valid,
   output logic       stuck
);

   localparam int             QW     = (DIV < 1) ? 1 : $clog2(DIV + 1);
   localparam logic [QW-1:0]  Q_LAST = QW'(DIV);
   localparam logic [8:0]     TO_CNT = 9'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;

   logic          sync1;
   logic          s;
   logic [QW-1:0] q;
   logic          tick;
   logic          smp;
   logic          smp_new;
   logic [1:0]    arm_wait;
   logic          rise;
   logic          timeout;
   logic [8:0]    per_cnt;
   logic [8:0]    hi_cnt;

   logic          frame_start;
   logic          frame_count;
   logic          frame_done;
   logic          stuck_done;

   // ------------------------------------------------------------------
   // Two-flop synchroniser for the asynchronous PWM input
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         s     <= sync1;
      end
   end

   // ------------------------------------------------------------------
   // Prescaler: 0..DIV, held at 0 in IDLE so the first tick after
   // arming comes immediately.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (!ena || state == IDLE) begin
         q <= '0;
      end else if (q == Q_LAST) begin
         q <= '0;
      end else begin
         q <= q + QW'(1);
      end
   end

   assign tick = ena && (state != IDLE) && (q == '0);

   // ------------------------------------------------------------------
   // Tick sample, optionally glitch-filtered
   // ------------------------------------------------------------------
`ifdef PWM_DECODER_GLITCH_FILTER_EN
   logic s_d1;
   logic s_d2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_d1 <= 1'b0;
         s_d2 <= 1'b0;
      end else begin
         s_d1 <= s;
         s_d2 <= s_d1;
      end
   end

   // Follow s only when it has been stable for three consecutive clk.
   assign smp_new = ((s == s_d1) && (s == s_d2)) ? s : smp;
`else
   assign smp_new = s;
`endif

   // In IDLE the sample tracks the input every clk, so arming never sees a
   // stale low level from before the block was disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp <= 1'b0;
      end else if (state == IDLE || tick) begin
         smp <= smp_new;
      end
   end

   // The first two ticks after arming only prime the sample. Right after
   // reset the synchroniser still carries its reset zeros, and a high
   // input would otherwise look like a rise in the middle of a frame and
   // produce a partial first report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_wait <= 2'd2;
      end else if (state == IDLE) begin
         arm_wait <= 2'd2;
      end else if (tick && arm_wait != 2'd0) begin
         arm_wait <= arm_wait - 2'd1;
      end
   end

   // A rise is decided on the tick that samples the new high level.
   // A rise on the same tick as the timeout takes priority.
   assign rise    = tick && smp_new && !smp && (arm_wait == 2'd0);
   assign timeout = tick && !rise && (state == MEAS) && (per_cnt == TO_CNT);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      if (!ena) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = ARM;
            ARM:     if (rise) state_next = MEAS;
            MEAS:    if (timeout) state_next = ARM;
            default: state_next = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM: control outputs
   // ------------------------------------------------------------------
   always_comb begin
      frame_start = 1'b0;
      frame_count = 1'b0;
      frame_done  = 1'b0;
      stuck_done  = 1'b0;
      case (state)
         ARM: begin
            frame_start = rise;
         end
         MEAS: begin
            if (rise) begin
               frame_done  = 1'b1;
               frame_start = 1'b1;
            end else if (timeout) begin
               stuck_done  = 1'b1;
            end else begin
               frame_count = tick;
            end
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Frame counters. The rise tick itself counts as one high tick and one
   // period tick. TIMEOUT caps per_cnt and hi_cnt never exceeds per_cnt,
   // so neither can wrap.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt <= 9'd0;
         hi_cnt  <= 9'd0;
      end else if (frame_start) begin
         per_cnt <= 9'd1;
         hi_cnt  <= 9'd1;
      end else if (frame_count) begin
         per_cnt <= per_cnt + 9'd1;
         if (smp_new) begin
            hi_cnt <= hi_cnt + 9'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Report registers; they hold between reports and while disabled.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_out   <= 8'd0;
         period_out <= 9'd0;
         valid      <= 1'b0;
         stuck      <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (frame_done) begin
            duty_out   <= hi_cnt[8] ? 8'hFF : hi_cnt[7:0];
            period_out <= per_cnt;
            stuck      <= 1'b0;
            valid      <= 1'b1;
         end else if (stuck_done) begin
            // Constant level: report the level as 0 % or 100 % duty.
            duty_out   <= smp_new ? 8'hFF : 8'h00;
            period_out <= 9'd0;
            stuck      <= 1'b1;
            valid      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_decoder
//
// Self-checking bench for pwm_duty_decoder (DIV=19, TIMEOUT=511, 10 MHz).
// A behavioural model keeps the list of tick samples of the current frame
// and derives each report from it (period = number of samples, duty =
// number of high samples). Every clk the DUT outputs are compared with the
// model; each scenario also checks the reports against hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_duty_decoder;

   localparam int DIV     = 19;
   localparam int TIMEOUT = 511;
   localparam int TPER    = DIV + 1;
   localparam int HALF    = 128 * TPER;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       pwm_in = 1'b0;
   logic [7:0] duty_out;
   logic [8:0] period_out;
   logic       valid;
   logic       stuck;

   pwm_duty_decoder #(
      .DIV     (DIV),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .pwm_in     (pwm_in),
      .duty_out   (duty_out),
      .period_out (period_out),
      .valid      (valid),
      .stuck      (stuck)
   );

   always #50 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   bit         m_active, m_in_frame, m_last, m_p1, m_s, m_rise, smp_v;
   int         m_phase, m_prime, ones;
   bit         sample_q[$];
   logic [7:0] exp_duty;
   logic [8:0] exp_period;
   bit         exp_valid, exp_stuck;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
   bit         m_sd1, m_sd2;
`endif

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_active = 0; m_in_frame = 0; m_last = 0; m_p1 = 0; m_s = 0;
         m_phase = 0; m_prime = 2; sample_q.delete();
         exp_duty = 0; exp_period = 0; exp_valid = 0; exp_stuck = 0;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
         m_sd1 = 0; m_sd2 = 0;
`endif
      end else begin
         exp_valid = 0;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
         smp_v = (m_s == m_sd1 && m_s == m_sd2) ? m_s : m_last;
`else
         smp_v = m_s;
`endif
         if (!m_active) begin
            m_last  = smp_v;
            m_prime = 2;
            if (ena) begin
               m_active = 1;
               m_phase  = 0;
            end
         end else if (!ena) begin
            m_active   = 0;
            m_in_frame = 0;
            sample_q.delete();
         end else begin
            if (m_phase == 0) begin
               m_rise = smp_v && !m_last && (m_prime == 0);
               if (m_prime > 0) m_prime--;
               m_last = smp_v;
               if (m_rise) begin
                  if (m_in_frame) begin
                     ones = 0;
                     foreach (sample_q[i]) ones += int'(sample_q[i]);
                     exp_duty   = 8'((ones > 255) ? 255 : ones);
                     exp_period = 9'(sample_q.size());
                     exp_stuck  = 0;
                     exp_valid  = 1;
                  end
                  sample_q.delete();
                  sample_q.push_back(1'b1);
                  m_in_frame = 1;
               end else if (m_in_frame) begin
                  if (sample_q.size() == TIMEOUT) begin
                     exp_duty   = smp_v ? 8'd255 : 8'd0;
                     exp_period = 9'd0;
                     exp_stuck  = 1;
                     exp_valid  = 1;
                     m_in_frame = 0;
                     sample_q.delete();
                  end else begin
                     sample_q.push_back(smp_v);
                  end
               end
            end
            m_phase = (m_phase + 1) % TPER;
         end
`ifdef PWM_DECODER_GLITCH_FILTER_EN
         m_sd2 = m_sd1;
         m_sd1 = m_s;
`endif
         m_s  = m_p1;
         m_p1 = pwm_in;
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle compare against the model
   // ------------------------------------------------------------------
   initial forever begin
      @(negedge clk);
      n_cmp++;
      if (valid !== exp_valid || stuck !== exp_stuck ||
          duty_out !== exp_duty || period_out !== exp_period) begin
         n_fail++;
         $display("FAIL cycle @%0t: got valid=%0d stuck=%0d duty=%0d period=%0d, expected valid=%0d stuck=%0d duty=%0d period=%0d",
                  $time, valid, stuck, duty_out, period_out,
                  exp_valid, exp_stuck, exp_duty, exp_period);
      end
   end

   // Log of DUT reports for the hand-computed checks: {stuck, period, duty}
   logic [17:0] rep_q[$];
   initial forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
         rep_q.push_back({stuck, period_out, duty_out});
         $display("report @%0t: duty=%0d period=%0d stuck=%0d",
                  $time, duty_out, period_out, stuck);
      end
   end

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [17:0] get_rep(input int idx);
      if (idx < rep_q.size()) return rep_q[idx];
      return 18'h3FFFF;
   endfunction

   task automatic chk_rep(input string nm, input int idx, input int du,
                          input int per, input int st);
      logic [17:0] r;
      r = get_rep(idx);
      chk({nm, ".duty"},   32'(r[7:0]),  32'(du));
      chk({nm, ".period"}, 32'(r[16:8]), 32'(per));
      chk({nm, ".stuck"},  32'(r[17]),   32'(st));
   endtask

   task automatic drive(input logic level, input int n);
      pwm_in = level;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input int hi);
      drive(1'b1, hi * TPER);
      drive(1'b0, (256 - hi) * TPER);
   endtask

   // Wait (bounded) until the model's prescaler phase reaches p.
   task automatic align(input int p, output int w);
      w = 0;
      while (m_phase != p && w < 2 * TPER) begin
         @(negedge clk);
         w++;
      end
      chk("align_bound", 32'(m_phase), 32'(p));
   endtask

   // ------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------
   int w;
   logic [17:0] r;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("reset.duty",   32'(duty_out),   0);
      chk("reset.period", 32'(period_out), 0);
      chk("reset.valid",  32'(valid),      0);
      chk("reset.stuck",  32'(stuck),      0);
      #20 rst_n = 1'b1;
      @(negedge clk);
      ena = 1'b1;
      drive(1'b0, 200);
      align(10, w);   // ticks land mid-window of each high phase

      // 1-3: duty 64 x2, 255, 1, then 1-tick high and held low
      rep_q.delete();
      frame(64); frame(64); frame(255); frame(1);
      drive(1'b1, TPER);
      drive(1'b0, (TIMEOUT + 2) * TPER);
      chk("s1.count", 32'(rep_q.size()), 5);
      chk_rep("s1.d64a", 0, 64, 256, 0);
      chk_rep("s1.d64b", 1, 64, 256, 0);
      chk_rep("s2.d255", 2, 255, 256, 0);
      chk_rep("s2.d1",   3, 1, 256, 0);
      chk_rep("s3.low",  4, 0, 0, 1);

      // 3: held high
      rep_q.delete();
      drive(1'b1, (TIMEOUT + 2) * TPER);
      chk("s3h.count", 32'(rep_q.size()), 1);
      chk_rep("s3.high", 0, 255, 0, 1);

      // 4: reset mid-frame after a duty 128 report
      rep_q.delete();
      drive(1'b0, 100);
      frame(128);
      drive(1'b1, 1000);
      chk("s4.pre_count", 32'(rep_q.size()), 1);
      chk_rep("s4.pre", 0, 128, 256, 0);
      rep_q.delete();
      #20 rst_n = 1'b0;
      #1;
      chk("s4.rst_duty",   32'(duty_out),   0);
      chk("s4.rst_period", 32'(period_out), 0);
      chk("s4.rst_stuck",  32'(stuck),      0);
      repeat (3) @(negedge clk);
      #20 rst_n = 1'b1;
      drive(1'b1, HALF - 1003);
      drive(1'b0, HALF);
      frame(128);
      drive(1'b1, 1000);
      chk("s4.count", 32'(rep_q.size()), 1);
      chk_rep("s4.post", 0, 128, 256, 0);

      // 5: ena low for 1000 clk mid-frame
      rep_q.delete();
      ena = 1'b0;
      drive(1'b1, 1000);
      chk("s5.hold_count",  32'(rep_q.size()), 0);
      chk("s5.hold_duty",   32'(duty_out),     128);
      chk("s5.hold_period", 32'(period_out),   256);
      ena = 1'b1;
      drive(1'b1, HALF - 2000);
      drive(1'b0, HALF);
      frame(128);
      drive(1'b1, HALF);
      chk("s5.count", 32'(rep_q.size()), 1);
      chk_rep("s5.post", 0, 128, 256, 0);

      // 6: 2-clk glitch on the low phase, aimed at a tick sample
      rep_q.delete();
      drive(1'b0, 1000);
      align(TPER - 2, w);
      drive(1'b1, 2);
      drive(1'b0, HALF - 1000 - w - 2);
      frame(128);
      drive(1'b1, 4 * TPER);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      chk("s6.count", 32'(rep_q.size()), 2);
      chk_rep("s6.frame",  0, 128, 256, 0);
      chk_rep("s6.next",   1, 128, 256, 0);
`else
      chk("s6.count", 32'(rep_q.size()), 3);
      r = get_rep(0);
      chk("s6.cut_duty",   32'(r[7:0]),           128);
      chk("s6.cut_short",  32'(r[16:8] < 9'd256), 1);
      r = get_rep(1);
      chk("s6.glitch_duty",  32'(r[7:0]),           1);
      chk("s6.glitch_short", 32'(r[16:8] < 9'd256), 1);
      chk("s6.glitch_stuck", 32'(r[17]),            0);
      chk_rep("s6.next", 2, 128, 256, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
